// File: rtl/ep_seq_pkg.sv
// Shared constants, FSM encoding and index-width helper for the endpoint command sequencer.
package ep_seq_pkg;

    localparam logic [1:0] CMD_WIRE = 2'b00;
    localparam logic [1:0] CMD_TRIG = 2'b01;
    localparam logic [1:0] CMD_WAIT = 2'b10;
    localparam logic [1:0] CMD_RSVD = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StApply,
        StPost,
        StWait
    } seq_state_e;

    // Channel index width: enough for the larger channel set, never below one bit.
    function automatic int unsigned calc_idx_w(input int unsigned n_wire,
                                               input int unsigned n_trig);
        int unsigned n_max;
        n_max = (n_wire > n_trig) ? n_wire : n_trig;
        return (n_max <= 2) ? 1 : $clog2(n_max);
    endfunction

endpackage

// File: rtl/ep_cmd_fifo.sv
// Show-ahead command queue; push while full is dropped, push and pop may share an edge.
module ep_cmd_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok, pop_ok;

    // Extra pointer bit distinguishes full from empty when the addresses match.
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/ep_cmd_sequencer.sv
// Queued wire/trigger/wait command sequencer with settle and hold timing around each apply.
module ep_cmd_sequencer
    import ep_seq_pkg::*;
#(
    parameter int unsigned N_WIRE   = 6,
    parameter int unsigned N_TRIG   = 2,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned PRE_CYC  = 2,
    parameter int unsigned POST_CYC = 6,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned IDX_W    = calc_idx_w(N_WIRE, N_TRIG)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_type,
    input  logic [IDX_W-1:0]         cmd_idx,
    input  logic [DATA_W-1:0]        cmd_data,
    output logic [N_WIRE*DATA_W-1:0] wire_out,
    output logic [N_TRIG*DATA_W-1:0] trig_out,
    output logic                     busy,
    output logic                     done_pulse,
    output logic                     err_out,
    input  logic                     err_clr,
    output logic [15:0]              cmd_count
);

    localparam int unsigned CMD_W = 2 + IDX_W + DATA_W;
    localparam int unsigned CNT_W = (DATA_W > 32) ? DATA_W : 32;

    seq_state_e               state_q, state_d;
    logic [CMD_W-1:0]         cmd_q, cmd_d, cmd_sel, fifo_rdata;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [N_WIRE*DATA_W-1:0] wire_q, wire_d;
    logic [N_TRIG*DATA_W-1:0] trig_q, trig_d;
    logic                     err_q, err_d;
    logic                     done_q, done_d;
    logic [15:0]              count_q, count_d;
    logic                     fifo_pop, fifo_full, fifo_empty;
    logic                     apply_en, post_en, a_bad;
    logic [1:0]               a_type;
    logic [IDX_W-1:0]         a_idx;
    logic [DATA_W-1:0]        a_data;

    ep_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (cmd_valid),
        .wdata_i ({cmd_type, cmd_idx, cmd_data}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // In IDLE the command being popped is the queue head, otherwise the latched one.
    assign cmd_sel                  = (state_q == StIdle) ? fifo_rdata : cmd_q;
    assign {a_type, a_idx, a_data}  = cmd_sel;

    assign a_bad = (a_type == CMD_RSVD)
                || ((a_type == CMD_WIRE) && (32'(a_idx) >= N_WIRE))
                || ((a_type == CMD_TRIG) && (32'(a_idx) >= N_TRIG));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cmd_d    = cmd_q;
        fifo_pop = 1'b0;
        apply_en = 1'b0;
        post_en  = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cmd_d    = fifo_rdata;
                    if (PRE_CYC == 0) begin
                        state_d  = StApply;
                        apply_en = 1'b1;
                    end else begin
                        state_d = StPre;
                        cnt_d   = CNT_W'(PRE_CYC - 1);
                    end
                end
            end
            StPre: begin
                if (cnt_q == '0) begin
                    state_d  = StApply;
                    apply_en = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StApply: begin
                if ((a_type == CMD_WAIT) && (a_data != '0)) begin
                    state_d = StWait;
                    cnt_d   = CNT_W'(a_data) - CNT_W'(1);
                end else begin
                    post_en = 1'b1;
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    post_en = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StPost: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
        if (post_en) begin
            if (POST_CYC == 0) begin
                state_d = StIdle;
                done_d  = 1'b1;
            end else begin
                state_d = StPost;
                cnt_d   = CNT_W'(POST_CYC - 1);
            end
        end
    end

    // Outputs are registered on the edge that enters APPLY, so they are live during APPLY.
    always_comb begin
        wire_d  = wire_q;
        trig_d  = '0;
        err_d   = err_q;
        count_d = count_q;
        if (apply_en && !a_bad) begin
            for (int k = 0; k < N_WIRE; k++) begin
                if ((a_type == CMD_WIRE) && (a_idx == IDX_W'(k))) begin
                    wire_d[k*DATA_W +: DATA_W] = a_data;
                end
            end
            for (int k = 0; k < N_TRIG; k++) begin
                if ((a_type == CMD_TRIG) && (a_idx == IDX_W'(k))) begin
                    trig_d[k*DATA_W +: DATA_W] = a_data;
                end
            end
        end
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (apply_en && a_bad) begin
            err_d = 1'b1;
        end
        if (done_d) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            cmd_q   <= '0;
            wire_q  <= '0;
            trig_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            wire_q  <= wire_d;
            trig_q  <= trig_d;
            err_q   <= err_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    assign cmd_ready  = !fifo_full;
    assign wire_out   = wire_q;
    assign trig_out   = trig_q;
    assign busy       = (state_q != StIdle) || !fifo_empty;
    assign done_pulse = done_q;
    assign err_out    = err_q;
    assign cmd_count  = count_q;

endmodule

// File: tb/tb_ep_cmd_sequencer.sv
// Scoreboard bench: each accepted command queues its expected completion state;
// a monitor pops and compares on every done_pulse.
`timescale 1ns/1ps
module tb_ep_cmd_sequencer;
    import ep_seq_pkg::*;

    localparam int NW = 6;
    localparam int NT = 2;
    localparam int DW = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_type = 2'b00;
    logic [2:0]       cmd_idx = 3'd0;
    logic [DW-1:0]    cmd_data = '0;
    logic [NW*DW-1:0] wire_out;
    logic [NT*DW-1:0] trig_out;
    logic             busy, done_pulse, err_out;
    logic             err_clr = 1'b0;
    logic [15:0]      cmd_count;

    ep_cmd_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_type   (cmd_type),
        .cmd_idx    (cmd_idx),
        .cmd_data   (cmd_data),
        .wire_out   (wire_out),
        .trig_out   (trig_out),
        .busy       (busy),
        .done_pulse (done_pulse),
        .err_out    (err_out),
        .err_clr    (err_clr),
        .cmd_count  (cmd_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [NW*DW-1:0] wire_v;
        logic [NT*DW-1:0] trig_v;
        int               trig_n;
        logic             err;
        int               count;
        int               done_cyc;
    } exp_t;

    exp_t             exp_q[$];
    logic [NW*DW-1:0] m_wire = '0;
    logic             m_err = 1'b0;
    int               m_count = 0;
    int               tests = 0;
    int               fails = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after acceptance with cmd_valid still high.
    task automatic send(input logic [1:0] t, input int idx, input logic [DW-1:0] d,
                        input int done_off, output int acc);
        bit   ok;
        bit   bad;
        exp_t e;
        ok  = 0;
        acc = -1;
        cmd_valid = 1'b1;
        cmd_type  = t;
        cmd_idx   = 3'(idx);
        cmd_data  = d;
        for (int i = 0; i < 200; i++) begin
            ok = cmd_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            @(negedge clk);
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: cmd_ready=0 for 200 cycles, expected 1");
            cmd_valid = 1'b0;
            return;
        end
        acc = cyc;
        bad = (t == 2'b11) || (t == 2'b00 && idx >= NW) || (t == 2'b01 && idx >= NT);
        e.trig_v = '0;
        e.trig_n = 0;
        if (!bad && t == 2'b00) m_wire[idx*DW +: DW] = d;
        if (!bad && t == 2'b01) begin
            e.trig_v[idx*DW +: DW] = d;
            e.trig_n = (d != 0) ? 1 : 0;
        end
        if (bad) m_err = 1'b1;
        m_count++;
        e.wire_v   = m_wire;
        e.err      = m_err;
        e.count    = m_count;
        e.done_cyc = (done_off < 0) ? -1 : acc + done_off;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        cmd_valid = 1'b0;
        err_clr   = 1'b0;
        exp_q.delete();
        m_wire  = '0;
        m_err   = 1'b0;
        m_count = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (busy) begin
            fails++;
            $display("FAIL idle_timeout: busy=1 after %0d cycles, expected 0", limit);
        end
        @(negedge clk);
    endtask

    // Monitor: accumulate trigger activity, compare state on each completion.
    logic [NT*DW-1:0] trig_acc = '0;
    int               trig_n = 0;
    exp_t             mon_e;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                trig_acc = '0;
                trig_n   = 0;
            end else begin
                if (trig_out != '0) begin
                    trig_acc |= trig_out;
                    trig_n++;
                end
                if (done_pulse) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_done: done_pulse=1 at cycle %0d, expected 0", cyc);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("done_wire", wire_out, mon_e.wire_v);
                        check("done_trig", trig_acc, mon_e.trig_v);
                        check("done_trig_cycles", trig_n, mon_e.trig_n);
                        check("done_err", err_out, mon_e.err);
                        check("done_count", cmd_count, 16'(mon_e.count));
                        if (mon_e.done_cyc >= 0) check("done_cycle", cyc, mon_e.done_cyc);
                    end
                    trig_acc = '0;
                    trig_n   = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200us, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int               a, b, w, acc5;
        logic [NT*DW-1:0] trig_hit;
        logic             busy_hit;

        repeat (3) @(negedge clk);
        check("rst_wire", wire_out, 0);
        check("rst_trig", trig_out, 0);
        check("rst_err", err_out, 0);
        check("rst_count", cmd_count, 0);
        check("rst_done", done_pulse, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", cmd_ready, 1);
        reset = 1'b0;
        @(negedge clk);

        // WIRE ch0 = 1: visible from T+3, done at T+10.
        send(CMD_WIRE, 0, 32'd1, 10, a);
        cmd_valid = 1'b0;
        wait_cyc(a + 2);
        check("wire0_before_apply", wire_out[31:0], 0);
        wait_cyc(a + 3);
        check("wire0_at_apply", wire_out[31:0], 1);
        wait_idle(40);

        // TRIG ch1 = 1: single-cycle pulse.
        send(CMD_TRIG, 1, 32'd1, 10, a);
        cmd_valid = 1'b0;
        wait_cyc(a + 2);
        check("trig_before", trig_out, 0);
        wait_cyc(a + 3);
        check("trig_pulse", trig_out, 64'h1_0000_0000);
        wait_cyc(a + 4);
        check("trig_after", trig_out, 0);
        wait_idle(40);

        // Baseline WIRE ch5, then WAIT 31 delaying a second ch5 write by 40 cycles.
        send(CMD_WIRE, 5, 32'd5, 10, a);
        cmd_valid = 1'b0;
        wait_cyc(a + 2);
        check("wire5_before", wire_out[191:160], 0);
        wait_cyc(a + 3);
        check("wire5_at_apply", wire_out[191:160], 5);
        wait_idle(40);
        send(CMD_WAIT, 0, 32'd31, 41, b);
        send(CMD_WIRE, 5, 32'd7, 50, w);
        cmd_valid = 1'b0;
        check("wait_b2b_accept", w, b + 1);
        wait_cyc(w + 42);
        check("wire5_delayed_before", wire_out[191:160], 5);
        wait_cyc(w + 43);
        check("wire5_delayed_at", wire_out[191:160], 7);
        wait_idle(100);

        // Out-of-range wire index: error only.
        send(CMD_WIRE, 6, 32'hDEAD, 10, a);
        cmd_valid = 1'b0;
        wait_cyc(a + 3);
        check("bad_wire_err", err_out, 1);
        check("bad_wire_unchanged", wire_out, m_wire);
        wait_idle(40);

        // Bad trig index with err_clr on the same edge: set wins.
        send(CMD_TRIG, 3, 32'hF, 10, a);
        cmd_valid = 1'b0;
        wait_cyc(a + 2);
        err_clr = 1'b1;
        wait_cyc(a + 3);
        err_clr = 1'b0;
        check("err_set_wins", err_out, 1);
        check("bad_trig_no_pulse", trig_out, 0);
        wait_idle(40);

        send(2'b11, 0, 32'h55, 10, a);
        cmd_valid = 1'b0;
        wait_idle(40);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_err   = 1'b0;
        check("err_clear", err_out, 0);
        send(CMD_WIRE, 3, 32'h33, 10, a);
        cmd_valid = 1'b0;
        wait_idle(40);

        // Back-pressure: long WAIT holds the head while four commands fill the queue.
        apply_reset();
        send(CMD_WAIT, 0, 32'd40, 50, b);
        cmd_valid = 1'b0;
        wait_cyc(b + 1);
        for (int i = 0; i < 4; i++) send(CMD_WIRE, 2, 32'(11 + i), -1, a);
        check("fill_accept_edge", a, b + 5);
        check("full_ready_low", cmd_ready, 0);
        send(CMD_WIRE, 2, 32'd15, -1, acc5);
        cmd_valid = 1'b0;
        check("fifth_accept_edge", acc5, b + 52);
        wait_idle(200);
        check("b2b_count", cmd_count, 6);

        // Reset during an active trigger pulse drops it immediately.
        send(CMD_TRIG, 0, 32'hA5, -1, a);
        cmd_valid = 1'b0;
        wait_cyc(a + 2);
        @(posedge clk);
        #2;
        check("midpulse_trig_high", trig_out, 64'hA5);
        reset = 1'b1;
        #1;
        check("midpulse_trig_drop", trig_out, 0);
        apply_reset();

        // Reset during PRE of a queued TRIG with three commands behind it.
        send(CMD_WAIT, 0, 32'd10, -1, b);
        send(CMD_TRIG, 0, 32'hFF, -1, a);
        for (int i = 0; i < 3; i++) send(CMD_WIRE, i, 32'(100 + i), -1, a);
        cmd_valid = 1'b0;
        wait_cyc(b + 22);
        reset = 1'b1;
        #1;
        check("pre_rst_wire", wire_out, 0);
        check("pre_rst_trig", trig_out, 0);
        check("pre_rst_count", cmd_count, 0);
        check("pre_rst_busy", busy, 0);
        check("pre_rst_ready", cmd_ready, 1);
        apply_reset();
        trig_hit = '0;
        busy_hit = 1'b0;
        repeat (40) begin
            @(negedge clk);
            trig_hit |= trig_out;
            busy_hit |= busy;
        end
        check("post_rst_no_trig", trig_hit, 0);
        check("post_rst_idle", busy_hit, 0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
